// File: rtl/bfs_queue_pkg.sv
// Shared helpers for the BFS frontier row queues: lane-index width,
// popcount and lowest-set-bit encode over a lane mask.
package bfs_queue_pkg;

  // Masks are zero-extended to this width before entering the helpers.
  localparam int MAX_LANES = 32;

  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int popcount(input logic [MAX_LANES-1:0] m);
    int c;
    c = 0;
    for (int i = 0; i < MAX_LANES; i++) c += int'(m[i]);
    return c;
  endfunction

  function automatic int lowest_set(input logic [MAX_LANES-1:0] m);
    int idx;
    idx = 0;
    for (int i = MAX_LANES-1; i >= 0; i--) if (m[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/bfs_lane_select.sv
// Picks the lowest valid lane of the head row and the mask left after popping it.
module bfs_lane_select
  import bfs_queue_pkg::*;
#(
  parameter int ENQ_LANES = 2,
  parameter int LANE_W    = lane_w(ENQ_LANES)
) (
  input  logic [ENQ_LANES-1:0] mask_in,
  output logic [LANE_W-1:0]    lane_out,
  output logic                 last_out,
  output logic [ENQ_LANES-1:0] next_mask_out
);

  logic [MAX_LANES-1:0] mask_ext;

  always_comb begin
    mask_ext                  = '0;
    mask_ext[ENQ_LANES-1:0]   = mask_in;
    lane_out                  = LANE_W'(lowest_set(mask_ext));
    // x & (x-1) clears exactly the lowest set bit
    next_mask_out             = mask_in & (mask_in - 1'b1);
    last_out                  = ~|next_mask_out;
  end

endmodule

// File: rtl/bfs_queue_multi.sv
// Circular row buffer for the BFS frontier: one multi-lane row in per cycle,
// one node ID out per cycle in lane order.
module bfs_queue_multi
  import bfs_queue_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ENQ_LANES = 2,
  parameter int Q_DEPTH   = 128,
  parameter int AF_MARGIN = 4
) (
  input  logic                                  clk,
  input  logic                                  bfs_rst,
  input  logic [ENQ_LANES-1:0]                  enqueue_req,
  input  logic [ENQ_LANES*DATA_W-1:0]           wdata_in,
  output logic                                  enq_ack,
  input  logic                                  dequeue_req,
  output logic [DATA_W-1:0]                     rdata_out,
  output logic [lane_w(ENQ_LANES)-1:0]          rlane_out,
  output logic                                  queue_full,
  output logic                                  queue_empty,
  output logic                                  almost_full,
  output logic [$clog2(Q_DEPTH*ENQ_LANES):0]    entry_count
);

  localparam int PTR_W  = $clog2(Q_DEPTH);
  localparam int LANE_W = lane_w(ENQ_LANES);
  localparam int CNT_W  = $clog2(Q_DEPTH*ENQ_LANES) + 1;

  typedef logic [ENQ_LANES-1:0][DATA_W-1:0] row_t;

  // Pointer MSB is the wrap polarity bit.
  logic [PTR_W:0]          head_q, head_d, tail_q, tail_d;
  logic [ENQ_LANES-1:0]    mask_q [Q_DEPTH];
  logic [ENQ_LANES-1:0]    mask_d [Q_DEPTH];
  logic [CNT_W-1:0]        count_q, count_d;
  row_t                    row_mem [Q_DEPTH];

  logic [PTR_W-1:0]        head_idx, tail_idx;
  logic [PTR_W:0]          used_rows;
  logic                    deq_eff;
  logic [LANE_W-1:0]       sel_lane;
  logic                    sel_last;
  logic [ENQ_LANES-1:0]    sel_next_mask;
  logic [MAX_LANES-1:0]    enq_ext;

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];

  bfs_lane_select #(.ENQ_LANES(ENQ_LANES), .LANE_W(LANE_W)) u_sel (
    .mask_in       (mask_q[head_idx]),
    .lane_out      (sel_lane),
    .last_out      (sel_last),
    .next_mask_out (sel_next_mask)
  );

  always_comb begin
    queue_empty = (head_q == tail_q);
    queue_full  = (head_idx == tail_idx) && (head_q[PTR_W] != tail_q[PTR_W]);
    used_rows   = tail_q - head_q;
    almost_full = (used_rows >= (PTR_W+1)'(Q_DEPTH - AF_MARGIN));
    enq_ack     = (|enqueue_req) && !queue_full;
    deq_eff     = dequeue_req && !queue_empty;
    rdata_out   = row_mem[head_idx][sel_lane];
    rlane_out   = sel_lane;
    entry_count = count_q;
  end

  always_comb begin
    enq_ext                  = '0;
    enq_ext[ENQ_LANES-1:0]   = enqueue_req;
    mask_d                   = mask_q;
    head_d                   = head_q;
    tail_d                   = tail_q;
    count_d                  = count_q;
    // Full is judged on registered state, so tail never lands on the head row here.
    if (enq_ack) begin
      mask_d[tail_idx] = enqueue_req;
      tail_d           = tail_q + 1'b1;
      count_d          = count_d + CNT_W'(popcount(enq_ext));
    end
    if (deq_eff) begin
      mask_d[head_idx] = sel_next_mask;
      if (sel_last) head_d = head_q + 1'b1;
      count_d          = count_d - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bfs_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Q_DEPTH; i++) mask_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mask_q  <= mask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ack && !bfs_rst) row_mem[tail_idx] <= row_t'(wdata_in);
  end

endmodule

// File: tb/tb_bfs_queue_multi.sv
// Randomized + directed bench for bfs_queue_multi against an entry-queue model.
module tb_bfs_queue_multi;

  localparam int DW  = 32;
  localparam int NL  = 2;
  localparam int QD  = 4;
  localparam int AFM = 1;

  logic          clk = 1'b0;
  logic          bfs_rst;
  logic [NL-1:0] enqueue_req;
  logic [NL*DW-1:0] wdata_in;
  logic          enq_ack;
  logic          dequeue_req;
  logic [DW-1:0] rdata_out;
  logic [0:0]    rlane_out;
  logic          queue_full, queue_empty, almost_full;
  logic [3:0]    entry_count;

  always #5 clk = ~clk;

  bfs_queue_multi #(.DATA_W(DW), .ENQ_LANES(NL), .Q_DEPTH(QD), .AF_MARGIN(AFM)) dut (
    .clk         (clk),
    .bfs_rst     (bfs_rst),
    .enqueue_req (enqueue_req),
    .wdata_in    (wdata_in),
    .enq_ack     (enq_ack),
    .dequeue_req (dequeue_req),
    .rdata_out   (rdata_out),
    .rlane_out   (rlane_out),
    .queue_full  (queue_full),
    .queue_empty (queue_empty),
    .almost_full (almost_full),
    .entry_count (entry_count)
  );

  typedef struct { logic [DW-1:0] d; int lane; } ent_t;
  ent_t ents[$];   // every held entry, in pop order
  int   rows[$];   // entries still held per occupied row

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic deq);
    logic exp_ack;
    int   pc;
    @(negedge clk);
    bfs_rst     = 1'b0;
    enqueue_req = m;
    wdata_in    = {b, a};
    dequeue_req = deq;
    #1;
    exp_ack = (m != 2'b00) && (rows.size() != QD);
    chk("empty", queue_empty, rows.size() == 0);
    chk("full",  queue_full,  rows.size() == QD);
    chk("afull", almost_full, (QD - rows.size()) <= AFM);
    chk("count", entry_count, ents.size());
    chk("ack",   enq_ack,     exp_ack);
    if (rows.size() > 0) begin
      chk("rdata", rdata_out, ents[0].d);
      chk("rlane", rlane_out, ents[0].lane);
    end
    if (deq && rows.size() > 0) begin
      void'(ents.pop_front());
      rows[0]--;
      if (rows[0] == 0) void'(rows.pop_front());
    end
    if (exp_ack) begin
      pc = 0;
      if (m[0]) begin ents.push_back('{a, 0}); pc++; end
      if (m[1]) begin ents.push_back('{b, 1}); pc++; end
      rows.push_back(pc);
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    @(negedge clk);
    bfs_rst     = 1'b1;
    enqueue_req = m;
    wdata_in    = {32'hDEAD_0001, 32'hDEAD_0000};
    dequeue_req = 1'b1;
    ents.delete();
    rows.delete();
  endtask

  initial begin
    bfs_rst = 1'b1; enqueue_req = '0; wdata_in = '0; dequeue_req = 1'b0;
    repeat (2) @(negedge clk);
    // reset / idle
    cycle(2'b00, 0, 0, 0);
    cycle(2'b00, 0, 0, 0);
    // one full row, three pops
    cycle(2'b11, 32'hA, 32'hB, 0);
    repeat (3) cycle(2'b00, 0, 0, 1);
    cycle(2'b00, 0, 0, 0);
    // fill with mixed masks, overfill, full + pop
    cycle(2'b01, 1, 0, 0);
    cycle(2'b10, 0, 2, 0);
    cycle(2'b11, 3, 4, 0);
    cycle(2'b01, 5, 0, 0);
    cycle(2'b11, 8, 9, 0);
    cycle(2'b01, 6, 0, 1);
    cycle(2'b01, 7, 0, 0);
    repeat (7) cycle(2'b00, 0, 0, 1);
    // single-lane streaming across the wrap point
    for (int i = 0; i < 10; i++) cycle(2'b01, 32'h100 + i, 0, i != 0);
    repeat (2) cycle(2'b00, 0, 0, 1);
    // reset with 3 rows held and an enqueue pending
    for (int i = 0; i < 3; i++) cycle(2'b11, 32'h200 + i, 32'h300 + i, 0);
    do_reset(2'b11);
    cycle(2'b00, 0, 0, 0);
    cycle(2'b00, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(2'($urandom_range(0, 3)));
      else cycle(2'($urandom_range(0, 3)), $urandom, $urandom,
                 $urandom_range(0, 99) < ((i / 100) % 2 ? 70 : 40));
    end
    repeat (12) cycle(2'b00, 0, 0, 1);
    cycle(2'b00, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
